box_compositor: RTL and testbench

- Parametrised successor to the single-player rectangle colouring in the top level.
- Composites NUM_OBJ player rectangles, each coloured by its state code, onto the VGA pixel stream. Lower object index has priority.
- Snapshots object positions at frame start so a frame never tears.
- Reports per-object overlap (hitbox contact) once per frame.
- Sits between the player instances / vga_driver next_x,next_y and the vga_driver color_in.

---
 rtl/box_compositor_if.sv | 31 +++
 rtl/box_compositor.sv | 174 +++++++++++++++++
 tb/tb_box_compositor.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/box_compositor_if.sv
// Pixel-stream bundle between the VGA timing/player logic (master) and the
// rectangle compositor (slave).
interface box_compositor_if #(
  parameter int NUM_OBJ = 2,
  parameter int COORD_W = 10,
  parameter int STATE_W = 4
);
  // Valid-only stream: pix_valid qualifies pix_x/pix_y every cycle and
  // color_valid qualifies color_out; there is no ready, the sink never stalls.
  logic                       pix_valid;
  logic [COORD_W-1:0]         pix_x;
  logic [COORD_W-1:0]         pix_y;
  logic [NUM_OBJ*COORD_W-1:0] obj_posx;
  logic [NUM_OBJ*COORD_W-1:0] obj_posy;
  logic [NUM_OBJ*STATE_W-1:0] obj_state;
  logic [NUM_OBJ-1:0]         obj_en;
  logic [7:0]                 color_out;
  logic                       color_valid;
  logic [NUM_OBJ-1:0]         overlap;
  logic                       frame_done;

  modport master (
    output pix_valid, pix_x, pix_y, obj_posx, obj_posy, obj_state, obj_en,
    input  color_out, color_valid, overlap, frame_done
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, obj_posx, obj_posy, obj_state, obj_en,
    output color_out, color_valid, overlap, frame_done
  );
endinterface

// File: rtl/box_compositor.sv
// Composites NUM_OBJ state-coloured rectangles onto the VGA pixel stream with a
// fixed two-cycle latency and reports per-object hitbox overlap once per frame.
module box_compositor #(
  parameter int          NUM_OBJ  = 2,
  parameter int          COORD_W  = 10,
  parameter int          STATE_W  = 4,
  parameter int          BOX_W    = 100,
  parameter int          BOX_H    = 100,
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter logic [7:0]  BG_COLOR = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  box_compositor_if.slave  bus
);

  localparam logic [COORD_W:0]   BOX_W_EXT = (COORD_W+1)'(BOX_W);
  localparam logic [COORD_W:0]   BOX_H_EXT = (COORD_W+1)'(BOX_H);
  localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(V_ACTIVE - 1);

  function automatic logic [7:0] palette(input logic [STATE_W-1:0] code);
    logic [31:0] c;
    c = 32'(code);
    case (c)
      32'd0:   palette = 8'b11100000;
      32'd1:   palette = 8'b00001111;
      32'd2:   palette = 8'b11110000;
      32'd3:   palette = 8'b00011111;
      32'd4:   palette = 8'b11111100;
      32'd5:   palette = 8'b11111111;
      default: palette = 8'h00;
    endcase
  endfunction

  // Frame-stable copy of the object table, reloaded only on the (0,0) pixel.
  logic [NUM_OBJ*COORD_W-1:0] shadow_posx;
  logic [NUM_OBJ*COORD_W-1:0] shadow_posy;
  logic [NUM_OBJ*STATE_W-1:0] shadow_state;
  logic [NUM_OBJ-1:0]         shadow_en;

  logic                       frame_start;
  logic [NUM_OBJ-1:0]         hit_d;
  logic [STATE_W-1:0]         sel_state_d;

  logic                       s1_valid;
  logic [COORD_W-1:0]         s1_x;
  logic [COORD_W-1:0]         s1_y;
  logic [NUM_OBJ-1:0]         s1_hit;
  logic [STATE_W-1:0]         s1_state;

  logic                       seen_one;
  logic                       multi_hit;
  logic [NUM_OBJ-1:0]         contrib;
  logic                       last_pixel;
  logic [NUM_OBJ-1:0]         acc;

  logic [7:0]                 color_d;
  logic [7:0]                 color_q;
  logic                       color_valid_q;
  logic [NUM_OBJ-1:0]         overlap_q;
  logic                       frame_done_q;

  assign frame_start = bus.pix_valid && (bus.pix_x == '0) && (bus.pix_y == '0);

  // Box extents are formed one bit wider so a box near the far edge is clipped
  // rather than wrapping around to the left/top of the screen.
  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_obj
    logic [COORD_W-1:0] px;
    logic [COORD_W-1:0] py;
    logic [COORD_W:0]   x_end;
    logic [COORD_W:0]   y_end;

    assign px    = shadow_posx[g*COORD_W +: COORD_W];
    assign py    = shadow_posy[g*COORD_W +: COORD_W];
    assign x_end = {1'b0, px} + BOX_W_EXT;
    assign y_end = {1'b0, py} + BOX_H_EXT;

    assign hit_d[g] = bus.pix_valid && shadow_en[g]
                   && (bus.pix_x >= px) && ({1'b0, bus.pix_x} < x_end)
                   && (bus.pix_y >= py) && ({1'b0, bus.pix_y} < y_end);
  end

  // State is captured with the hit so the frame-start pixel keeps the colours
  // of the snapshot it was tested against, even though the shadow reloads.
  always_comb begin
    sel_state_d = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (hit_d[i]) sel_state_d = shadow_state[i*STATE_W +: STATE_W];
    end
  end

  always_comb begin
    seen_one  = 1'b0;
    multi_hit = 1'b0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (s1_hit[i]) begin
        if (seen_one) multi_hit = 1'b1;
        seen_one = 1'b1;
      end
    end
  end

  assign contrib    = (s1_valid && multi_hit) ? s1_hit : '0;
  assign last_pixel = s1_valid && (s1_x == X_LAST) && (s1_y == Y_LAST);

  always_comb begin
    color_d = 8'h00;
    if (s1_valid) color_d = (|s1_hit) ? palette(s1_state) : BG_COLOR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_posx  <= '0;
      shadow_posy  <= '0;
      shadow_state <= '0;
      shadow_en    <= '0;
    end else if (frame_start) begin
      shadow_posx  <= bus.obj_posx;
      shadow_posy  <= bus.obj_posy;
      shadow_state <= bus.obj_state;
      shadow_en    <= bus.obj_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_hit   <= '0;
      s1_state <= '0;
    end else begin
      s1_valid <= bus.pix_valid;
      s1_x     <= bus.pix_x;
      s1_y     <= bus.pix_y;
      s1_hit   <= hit_d;
      s1_state <= sel_state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color_q       <= BG_COLOR;
      color_valid_q <= 1'b0;
    end else begin
      color_q       <= color_d;
      color_valid_q <= s1_valid;
    end
  end

  // The last pixel's own contribution is folded into the published value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      overlap_q    <= '0;
      frame_done_q <= 1'b0;
    end else if (last_pixel) begin
      acc          <= '0;
      overlap_q    <= acc | contrib;
      frame_done_q <= 1'b1;
    end else begin
      acc          <= acc | contrib;
      frame_done_q <= 1'b0;
    end
  end

  assign bus.color_out   = color_q;
  assign bus.color_valid = color_valid_q;
  assign bus.overlap     = overlap_q;
  assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_box_compositor.sv
// Directed bench for box_compositor: sparse pixel streams stand in for full
// frames, since only the (0,0) and last active pixel carry frame meaning.
module tb_box_compositor;

  localparam int         NUM_OBJ = 2;
  localparam int         COORD_W = 10;
  localparam int         STATE_W = 4;
  localparam logic [7:0] BG      = 8'h25;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   fd_count;

  box_compositor_if #(.NUM_OBJ(NUM_OBJ), .COORD_W(COORD_W), .STATE_W(STATE_W)) bus ();

  box_compositor #(
    .NUM_OBJ(NUM_OBJ), .COORD_W(COORD_W), .STATE_W(STATE_W),
    .BOX_W(100), .BOX_H(100), .H_ACTIVE(640), .V_ACTIVE(480), .BG_COLOR(BG)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #20 clk = ~clk;

  always @(negedge clk) if (bus.frame_done === 1'b1) fd_count++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic set_obj(input int idx, input int x, input int y, input int st, input logic en);
    bus.obj_posx[idx*COORD_W +: COORD_W]  = COORD_W'(x);
    bus.obj_posy[idx*COORD_W +: COORD_W]  = COORD_W'(y);
    bus.obj_state[idx*STATE_W +: STATE_W] = STATE_W'(st);
    bus.obj_en[idx]                       = en;
  endtask

  // Drive one valid pixel, then idle; return the output two clocks later.
  task automatic probe(input int x, input int y, output logic [7:0] c, output logic v);
    @(negedge clk);
    bus.pix_valid = 1'b1;
    bus.pix_x     = COORD_W'(x);
    bus.pix_y     = COORD_W'(y);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    @(negedge clk);
    c = bus.color_out;
    v = bus.color_valid;
  endtask

  task automatic start_frame();
    @(negedge clk);
    bus.pix_valid = 1'b1;
    bus.pix_x     = '0;
    bus.pix_y     = '0;
    @(negedge clk);
    bus.pix_valid = 1'b0;
  endtask

  task automatic end_frame(output logic fd, output logic fd_after, output logic [NUM_OBJ-1:0] ov);
    @(negedge clk);
    bus.pix_valid = 1'b1;
    bus.pix_x     = COORD_W'(639);
    bus.pix_y     = COORD_W'(479);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    @(negedge clk);
    fd = bus.frame_done;
    ov = bus.overlap;
    @(negedge clk);
    fd_after = bus.frame_done;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.color_out !== BG) begin failures++; $display("FAIL reset_color: got %h expected %h", bus.color_out, BG); end
    checks++; if (bus.color_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus.color_valid); end
    checks++; if (bus.overlap !== 2'b00) begin failures++; $display("FAIL reset_overlap: got %b expected 00", bus.overlap); end
    checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done: got %b expected 0", bus.frame_done); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_box();
    logic [7:0] c; logic v; logic fd, fda; logic [NUM_OBJ-1:0] ov;
    set_obj(0, 10, 20, 0, 1'b1);
    set_obj(1, 0, 0, 1, 1'b0);
    start_frame();
    probe(10, 20, c, v);
    checks++; if (c !== 8'hE0 || v !== 1'b1) begin failures++; $display("FAIL single_top_left: got %h/%b expected e0/1", c, v); end
    probe(109, 119, c, v);
    checks++; if (c !== 8'hE0 || v !== 1'b1) begin failures++; $display("FAIL single_bot_right: got %h/%b expected e0/1", c, v); end
    probe(110, 20, c, v);
    checks++; if (c !== BG || v !== 1'b1) begin failures++; $display("FAIL single_right_edge: got %h/%b expected %h/1", c, v, BG); end
    probe(9, 20, c, v);
    checks++; if (c !== BG || v !== 1'b1) begin failures++; $display("FAIL single_left_edge: got %h/%b expected %h/1", c, v, BG); end
    probe(50, 120, c, v);
    checks++; if (c !== BG || v !== 1'b1) begin failures++; $display("FAIL single_bottom_edge: got %h/%b expected %h/1", c, v, BG); end
    // in-box coordinates presented with pix_valid low
    @(negedge clk);
    bus.pix_x = COORD_W'(50);
    bus.pix_y = COORD_W'(50);
    repeat (2) @(negedge clk);
    checks++; if (bus.color_out !== 8'h00 || bus.color_valid !== 1'b0) begin failures++; $display("FAIL single_invalid_pixel: got %h/%b expected 00/0", bus.color_out, bus.color_valid); end
    end_frame(fd, fda, ov);
    checks++; if (fd !== 1'b1 || fda !== 1'b0 || ov !== 2'b00) begin failures++; $display("FAIL single_frame_end: fd=%b after=%b ov=%b expected 1/0/00", fd, fda, ov); end
  endtask

  task automatic test_overlap();
    logic [7:0] c; logic v; logic fd, fda; logic [NUM_OBJ-1:0] ov;
    set_obj(0, 100, 100, 1, 1'b1);
    set_obj(1, 150, 150, 3, 1'b1);
    start_frame();
    probe(160, 160, c, v);
    checks++; if (c !== 8'h0F || v !== 1'b1) begin failures++; $display("FAIL overlap_priority: got %h/%b expected 0f/1", c, v); end
    probe(210, 210, c, v);
    checks++; if (c !== 8'h1F || v !== 1'b1) begin failures++; $display("FAIL overlap_obj1_only: got %h/%b expected 1f/1", c, v); end
    end_frame(fd, fda, ov);
    checks++; if (fd !== 1'b1 || fda !== 1'b0) begin failures++; $display("FAIL overlap_pulse: fd=%b after=%b expected 1/0", fd, fda); end
    checks++; if (ov !== 2'b11) begin failures++; $display("FAIL overlap_value: got %b expected 11", ov); end
  endtask

  task automatic test_apart();
    logic [7:0] c; logic v; logic fd, fda; logic [NUM_OBJ-1:0] ov; int fd_before;
    set_obj(1, 300, 300, 3, 1'b1);
    start_frame();
    fd_before = fd_count;
    probe(310, 310, c, v);
    checks++; if (c !== 8'h1F || v !== 1'b1) begin failures++; $display("FAIL apart_obj1: got %h/%b expected 1f/1", c, v); end
    probe(160, 160, c, v);
    checks++; if (c !== 8'h0F || v !== 1'b1) begin failures++; $display("FAIL apart_obj0: got %h/%b expected 0f/1", c, v); end
    checks++; if (fd_count !== fd_before) begin failures++; $display("FAIL apart_no_midframe_pulse: pulses=%0d expected %0d", fd_count, fd_before); end
    end_frame(fd, fda, ov);
    checks++; if (fd !== 1'b1 || ov !== 2'b00) begin failures++; $display("FAIL apart_frame_end: fd=%b ov=%b expected 1/00", fd, ov); end
  endtask

  task automatic test_palette();
    logic [7:0] c; logic v; logic fd, fda; logic [NUM_OBJ-1:0] ov;
    set_obj(0, 0, 200, 2, 1'b1);
    set_obj(1, 300, 200, 4, 1'b1);
    start_frame();
    probe(10, 210, c, v);
    checks++; if (c !== 8'hF0) begin failures++; $display("FAIL palette_2: got %h expected f0", c); end
    probe(310, 210, c, v);
    checks++; if (c !== 8'hFC) begin failures++; $display("FAIL palette_4: got %h expected fc", c); end
    end_frame(fd, fda, ov);
    set_obj(0, 0, 200, 5, 1'b1);
    set_obj(1, 300, 200, 9, 1'b1);
    start_frame();
    probe(10, 210, c, v);
    checks++; if (c !== 8'hFF) begin failures++; $display("FAIL palette_5: got %h expected ff", c); end
    probe(310, 210, c, v);
    checks++; if (c !== 8'h00 || v !== 1'b1) begin failures++; $display("FAIL palette_unknown: got %h/%b expected 00/1", c, v); end
    end_frame(fd, fda, ov);
  endtask

  task automatic test_midframe_change();
    logic [7:0] c; logic v; logic fd, fda; logic [NUM_OBJ-1:0] ov;
    set_obj(0, 10, 20, 0, 1'b1);
    set_obj(1, 300, 300, 3, 1'b0);
    start_frame();
    probe(15, 100, c, v);
    checks++; if (c !== 8'hE0) begin failures++; $display("FAIL mid_before_move: got %h expected e0", c); end
    set_obj(0, 200, 20, 0, 1'b1);
    set_obj(1, 300, 300, 3, 1'b1);
    probe(15, 100, c, v);
    checks++; if (c !== 8'hE0) begin failures++; $display("FAIL mid_old_pos_kept: got %h expected e0", c); end
    probe(205, 100, c, v);
    checks++; if (c !== BG) begin failures++; $display("FAIL mid_new_pos_hidden: got %h expected %h", c, BG); end
    probe(310, 310, c, v);
    checks++; if (c !== BG) begin failures++; $display("FAIL mid_late_enable: got %h expected %h", c, BG); end
    probe(15, 240, c, v);
    checks++; if (c !== BG) begin failures++; $display("FAIL mid_line240: got %h expected %h", c, BG); end
    end_frame(fd, fda, ov);
    start_frame();
    probe(205, 100, c, v);
    checks++; if (c !== 8'hE0) begin failures++; $display("FAIL next_new_pos: got %h expected e0", c); end
    probe(15, 100, c, v);
    checks++; if (c !== BG) begin failures++; $display("FAIL next_old_pos_gone: got %h expected %h", c, BG); end
    probe(310, 310, c, v);
    checks++; if (c !== 8'h1F) begin failures++; $display("FAIL next_obj1_enabled: got %h expected 1f", c); end
    end_frame(fd, fda, ov);
  endtask

  task automatic test_edge_clip();
    logic [7:0] c; logic v; logic fd, fda; logic [NUM_OBJ-1:0] ov;
    set_obj(0, 0, 0, 0, 1'b1);
    set_obj(1, 0, 0, 0, 1'b0);
    start_frame();
    end_frame(fd, fda, ov);
    set_obj(0, 1000, 470, 0, 1'b1);
    // this (0,0) is itself the frame start: it must use the box at (0,0)
    probe(0, 0, c, v);
    checks++; if (c !== 8'hE0) begin failures++; $display("FAIL start_pixel_old_snapshot: got %h expected e0", c); end
    probe(1020, 475, c, v);
    checks++; if (c !== 8'hE0) begin failures++; $display("FAIL clip_drawn: got %h expected e0", c); end
    probe(5, 475, c, v);
    checks++; if (c !== BG) begin failures++; $display("FAIL clip_no_wrap_x: got %h expected %h", c, BG); end
    probe(1020, 5, c, v);
    checks++; if (c !== BG) begin failures++; $display("FAIL clip_no_wrap_y: got %h expected %h", c, BG); end
    end_frame(fd, fda, ov);
  endtask

  task automatic test_reset_midframe();
    logic [7:0] c; logic v; logic fd, fda; logic [NUM_OBJ-1:0] ov;
    set_obj(0, 100, 100, 1, 1'b1);
    set_obj(1, 150, 150, 3, 1'b1);
    start_frame();
    probe(160, 160, c, v);
    end_frame(fd, fda, ov);
    checks++; if (ov !== 2'b11) begin failures++; $display("FAIL rst_pre_overlap: got %b expected 11", ov); end
    start_frame();
    @(negedge clk);
    bus.pix_valid = 1'b1;
    bus.pix_x     = COORD_W'(160);
    bus.pix_y     = COORD_W'(160);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.color_out !== BG || bus.color_valid !== 1'b0) begin failures++; $display("FAIL rst_async_color: got %h/%b expected %h/0", bus.color_out, bus.color_valid, BG); end
    checks++; if (bus.overlap !== 2'b00) begin failures++; $display("FAIL rst_async_overlap: got %b expected 00", bus.overlap); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    probe(160, 160, c, v);
    checks++; if (c !== BG || v !== 1'b1) begin failures++; $display("FAIL rst_no_draw: got %h/%b expected %h/1", c, v, BG); end
    checks++; if (bus.overlap !== 2'b00) begin failures++; $display("FAIL rst_overlap_held: got %b expected 00", bus.overlap); end
    end_frame(fd, fda, ov);
    checks++; if (fd !== 1'b1 || ov !== 2'b00) begin failures++; $display("FAIL rst_first_publish: fd=%b ov=%b expected 1/00", fd, ov); end
    probe(0, 0, c, v);
    checks++; if (c !== BG) begin failures++; $display("FAIL rst_start_pixel: got %h expected %h", c, BG); end
    probe(160, 160, c, v);
    checks++; if (c !== 8'h0F) begin failures++; $display("FAIL rst_redraw: got %h expected 0f", c); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks        = 0;
    failures      = 0;
    fd_count      = 0;
    rst_n         = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_x     = '0;
    bus.pix_y     = '0;
    bus.obj_posx  = '0;
    bus.obj_posy  = '0;
    bus.obj_state = '0;
    bus.obj_en    = '0;

    test_reset();
    test_single_box();
    test_overlap();
    test_apart();
    test_palette();
    test_midframe_change();
    test_edge_clip();
    test_reset_midframe();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
